// File: rtl/llc_bus_initiator_pkg.sv
// ----------------------------------------------------------------------------
// cache_define: shared types and helpers for the LLC bus initiator.
//   bus_op_t    : bus operation codes (READ=1 WRITE=2 INVALIDATE=3 RWIM=4)
//   snoop_res_t : per-peer snoop result (HIT=00 HITM=01 NOHIT=10, 11 illegal)
//   mesi_t      : requester line state (M=00 E=01 S=10 I=11)
//   combine_snoop() : HITM > HIT > NOHIT priority merge of two legal results
//   op_to_mesi()    : final MESI state for the requester from op and result
// ----------------------------------------------------------------------------
package cache_define;

    typedef enum logic [2:0] {
        OP_NONE       = 3'd0,
        OP_READ       = 3'd1,
        OP_WRITE      = 3'd2,
        OP_INVALIDATE = 3'd3,
        OP_RWIM       = 3'd4
    } bus_op_t;

    typedef enum logic [1:0] {
        SNP_HIT     = 2'b00,
        SNP_HITM    = 2'b01,
        SNP_NOHIT   = 2'b10,
        SNP_ILLEGAL = 2'b11
    } snoop_res_t;

    typedef enum logic [1:0] {
        MESI_M = 2'b00,
        MESI_E = 2'b01,
        MESI_S = 2'b10,
        MESI_I = 2'b11
    } mesi_t;

    function automatic snoop_res_t combine_snoop(input snoop_res_t a, input snoop_res_t b);
        if (a == SNP_HITM || b == SNP_HITM) return SNP_HITM;
        if (a == SNP_HIT  || b == SNP_HIT)  return SNP_HIT;
        return SNP_NOHIT;
    endfunction

    function automatic mesi_t op_to_mesi(input bus_op_t op, input snoop_res_t res);
        case (op)
            OP_READ:       return (res == SNP_NOHIT) ? MESI_E : MESI_S;
            OP_RWIM:       return MESI_M;
            OP_INVALIDATE: return MESI_M;
            default:       return MESI_I;  // WRITE evicts the line
        endcase
    endfunction

endpackage

// File: rtl/llc_bus_initiator_snoop_collector.sv
// ----------------------------------------------------------------------------
// llc_snoop_collector: gathers one snoop result per peer cache.
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : empty the mask before a new collection window
//   en_i          : strobes are captured only while high
//   snp_valid_i   : per-peer result strobe
//   snp_result_i  : per-peer 2-bit snoop_res_t
//   all_seen_o    : every peer has reported (including this cycle's strobes)
//   combined_o    : priority merge of reported results; silent peers = NOHIT
//   illegal_o     : a reported result used the illegal 11 encoding
// Outputs are computed from the post-update view so the parent can exit on
// the same cycle the last strobe arrives.
// ----------------------------------------------------------------------------
module llc_snoop_collector
    import cache_define::*;
#(
    parameter int N_SNOOP = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   en_i,
    input  logic [N_SNOOP-1:0]     snp_valid_i,
    input  logic [2*N_SNOOP-1:0]   snp_result_i,
    output logic                   all_seen_o,
    output snoop_res_t             combined_o,
    output logic                   illegal_o
);

    logic [N_SNOOP-1:0]   mask_q, mask_d;
    logic [2*N_SNOOP-1:0] res_q, res_d;

    always_comb begin
        mask_d     = mask_q;
        res_d      = res_q;
        combined_o = SNP_NOHIT;
        illegal_o  = 1'b0;
        if (en_i) begin
            for (int unsigned i = 0; i < N_SNOOP; i++) begin
                // first strobe per peer wins; repeats are dropped
                if (snp_valid_i[i] && !mask_q[i]) begin
                    mask_d[i]        = 1'b1;
                    res_d[2*i +: 2]  = snp_result_i[2*i +: 2];
                end
            end
        end
        all_seen_o = &mask_d;
        for (int unsigned i = 0; i < N_SNOOP; i++) begin
            if (mask_d[i]) begin
                if (res_d[2*i +: 2] == SNP_ILLEGAL)
                    illegal_o = 1'b1;
                else
                    combined_o = combine_snoop(combined_o, snoop_res_t'(res_d[2*i +: 2]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            mask_q <= '0;
            res_q  <= '0;
        end else begin
            mask_q <= mask_d;
            res_q  <= res_d;
        end
    end

endmodule

// File: rtl/llc_bus_initiator.sv
// ----------------------------------------------------------------------------
// llc_bus_initiator: issues one bus operation per LLC request, arbitrates,
// collects peer snoop results, waits for a HITM writeback when needed and
// reports the combined result plus the requester's MESI state.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_op, req_addr          : bus_op_t and line address of the request
//   bus_valid/bus_grant       : bus request held until granted
//   bus_op, bus_addr          : latched operation and address
//   snp_valid, snp_result     : per-peer snoop strobes and results
//   wb_done                   : HITM owner finished the writeback
//   done_valid                : one-cycle completion pulse
//   done_result/mesi/err      : held until the next completion
// Optional: define LLC_BUS_TRACE_EN to print a trace line on each completion.
// ----------------------------------------------------------------------------
module llc_bus_initiator
    import cache_define::*;
#(
    parameter int N_SNOOP = 3,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 bus_valid,
    output logic [2:0]           bus_op,
    output logic [ADDR_W-1:0]    bus_addr,
    input  logic                 bus_grant,
    input  logic [N_SNOOP-1:0]   snp_valid,
    input  logic [2*N_SNOOP-1:0] snp_result,
    input  logic                 wb_done,
    output logic                 done_valid,
    output logic [1:0]           done_result,
    output logic [1:0]           done_mesi,
    output logic                 done_err
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARB       = 3'd1;
    localparam logic [2:0] ST_COLLECT   = 3'd2;
    localparam logic [2:0] ST_HITM_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam int CNT_W = ($clog2(TIMEOUT) < 4) ? 4 : $clog2(TIMEOUT);

    logic [2:0]        state_q, state_d;
    bus_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    snoop_res_t        res_q, res_d;        // result of the transaction in flight
    logic              err_q, err_d;
    snoop_res_t        done_result_q, done_result_d;
    mesi_t             done_mesi_q, done_mesi_d;
    logic              done_err_q, done_err_d;

    logic              coll_clear;
    logic              all_seen;
    snoop_res_t        combined;
    logic              illegal;
    logic              cnt_last;

    llc_snoop_collector #(
        .N_SNOOP (N_SNOOP)
    ) u_collector (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (coll_clear),
        .en_i         (state_q == ST_COLLECT),
        .snp_valid_i  (snp_valid),
        .snp_result_i (snp_result),
        .all_seen_o   (all_seen),
        .combined_o   (combined),
        .illegal_o    (illegal)
    );

    assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        res_d         = res_q;
        err_d         = err_q;
        done_result_d = done_result_q;
        done_mesi_d   = done_mesi_q;
        done_err_d    = done_err_q;
        coll_clear    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = bus_op_t'(req_op);
                    addr_d  = req_addr;
                    res_d   = SNP_NOHIT;
                    err_d   = 1'b0;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (bus_grant) begin
                    if (op_q == OP_WRITE) begin
                        done_result_d = SNP_NOHIT;
                        done_mesi_d   = op_to_mesi(op_q, SNP_NOHIT);
                        done_err_d    = 1'b0;
                        state_d       = ST_DONE;
                    end else begin
                        cnt_d      = '0;
                        coll_clear = 1'b1;
                        state_d    = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                // all_seen takes precedence over a timeout on the same cycle;
                // on timeout the silent peers already read as NOHIT in combined
                if (all_seen || cnt_last) begin
                    res_d = combined;
                    err_d = err_q | illegal | ~all_seen;
                    if (combined == SNP_HITM && (op_q == OP_READ || op_q == OP_RWIM)) begin
                        cnt_d   = '0;
                        state_d = ST_HITM_WAIT;
                    end else begin
                        done_result_d = combined;
                        done_mesi_d   = op_to_mesi(op_q, combined);
                        done_err_d    = err_q | illegal | ~all_seen;
                        state_d       = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HITM_WAIT: begin
                if (wb_done || cnt_last) begin
                    done_result_d = res_q;
                    done_mesi_d   = op_to_mesi(op_q, res_q);
                    done_err_d    = err_q | ~wb_done;
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_NONE;
            addr_q        <= '0;
            cnt_q         <= '0;
            res_q         <= SNP_NOHIT;
            err_q         <= 1'b0;
            done_result_q <= SNP_NOHIT;
            done_mesi_q   <= MESI_I;
            done_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            res_q         <= res_d;
            err_q         <= err_d;
            done_result_q <= done_result_d;
            done_mesi_q   <= done_mesi_d;
            done_err_q    <= done_err_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign bus_valid   = (state_q == ST_ARB);
    assign bus_op      = op_q;
    assign bus_addr    = addr_q;
    assign done_valid  = (state_q == ST_DONE);
    assign done_result = done_result_q;
    assign done_mesi   = done_mesi_q;
    assign done_err    = done_err_q;

`ifdef LLC_BUS_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_DONE)
            $display("BusOp: %s, Address: %h, Snoop Result: %s, MESI: %s",
                     op_q.name(), addr_q, done_result_q.name(), done_mesi_q.name());
    end
`else
`endif

endmodule

// File: tb/tb_llc_bus_initiator.sv
module tb_llc_bus_initiator;

    localparam int N  = 3;
    localparam int TO = 16;

    localparam logic [2:0] C_READ  = 3'd1;
    localparam logic [2:0] C_WRITE = 3'd2;
    localparam logic [2:0] C_INV   = 3'd3;
    localparam logic [2:0] C_RWIM  = 3'd4;
    localparam logic [1:0] R_HIT   = 2'b00;
    localparam logic [1:0] R_HITM  = 2'b01;
    localparam logic [1:0] R_NOHIT = 2'b10;
    localparam logic [1:0] R_ILL   = 2'b11;
    localparam logic [1:0] M_M = 2'b00, M_E = 2'b01, M_S = 2'b10, M_I = 2'b11;

    logic           clk;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [2:0]     req_op;
    logic [31:0]    req_addr;
    logic           bus_valid;
    logic [2:0]     bus_op;
    logic [31:0]    bus_addr;
    logic           bus_grant;
    logic [N-1:0]   snp_valid;
    logic [2*N-1:0] snp_result;
    logic           wb_done;
    logic           done_valid;
    logic [1:0]     done_result;
    logic [1:0]     done_mesi;
    logic           done_err;

    int total = 0;
    int bad   = 0;

    // current transaction description
    logic [2:0]  t_op;
    logic [31:0] t_addr;
    int          t_g, t_w;
    int          t_off[N], t_rep[N];
    logic [1:0]  t_val[N], t_rval[N];

    llc_bus_initiator #(
        .N_SNOOP (N),
        .ADDR_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .bus_valid   (bus_valid),
        .bus_op      (bus_op),
        .bus_addr    (bus_addr),
        .bus_grant   (bus_grant),
        .snp_valid   (snp_valid),
        .snp_result  (snp_result),
        .wb_done     (wb_done),
        .done_valid  (done_valid),
        .done_result (done_result),
        .done_mesi   (done_mesi),
        .done_err    (done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int rank(input logic [1:0] v);
        case (v)
            R_HITM:  return 2;
            R_HIT:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] unrank(input int r);
        if (r == 2) return R_HITM;
        if (r == 1) return R_HIT;
        return R_NOHIT;
    endfunction

    task automatic set_txn(input logic [2:0] op, input logic [31:0] addr, input int g, input int w);
        t_op = op; t_addr = addr; t_g = g; t_w = w;
        for (int p = 0; p < N; p++) begin
            t_off[p] = -1; t_rep[p] = -1; t_val[p] = R_NOHIT; t_rval[p] = R_NOHIT;
        end
    endtask

    task automatic set_peer(input int p, input int off, input logic [1:0] v, input int rep, input logic [1:0] rv);
        t_off[p] = off; t_val[p] = v; t_rep[p] = rep; t_rval[p] = rv;
    endtask

    // one idle cycle with junk on every ignored input
    task automatic idle_junk();
        req_valid  = 1'b0;
        bus_grant  = 1'b1;
        snp_valid  = '1;
        snp_result = 6'($urandom);
        wb_done    = 1'b1;
        check("idle_ready", req_ready, 1);
        check("idle_done_valid", done_valid, 0);
        tick();
    endtask

    // Reference: per-peer first strobe times decide the collect window length,
    // the merged result, the error flag and the completion cycle.
    task automatic run_txn();
        int C, H, cc, wc, dc, last, best;
        logic tmo, ill, hw, ee;
        logic [1:0] er, em;
        logic [1:0] prev_res, prev_mesi;
        logic prev_err;

        C = 2 + t_g;
        hw = 1'b0; wc = 0; tmo = 1'b0; ill = 1'b0; best = 0;
        if (t_op == C_WRITE) begin
            dc = C; H = C; cc = 0;
            er = R_NOHIT; em = M_I; ee = 1'b0;
        end else begin
            last = -1;
            for (int p = 0; p < N; p++) begin
                if (t_off[p] < 0 || t_off[p] >= TO) tmo = 1'b1;
                else if (t_off[p] > last) last = t_off[p];
            end
            cc = tmo ? TO : last + 1;
            for (int p = 0; p < N; p++) begin
                if (t_off[p] >= 0 && t_off[p] < cc) begin
                    if (t_val[p] == R_ILL) ill = 1'b1;
                    else if (rank(t_val[p]) > best) best = rank(t_val[p]);
                end
            end
            er = unrank(best);
            ee = tmo | ill;
            hw = (best == 2) && (t_op == C_READ || t_op == C_RWIM);
            H  = C + cc;
            if (hw) begin
                if (t_w >= 0 && t_w < TO) wc = t_w + 1;
                else begin wc = TO; ee = 1'b1; end
            end
            dc = H + wc;
            if (t_op == C_READ) em = (best == 0) ? M_E : M_S;
            else                em = M_M;
        end

        prev_res = done_result; prev_mesi = done_mesi; prev_err = done_err;

        for (int k = 0; k <= dc; k++) begin
            req_valid = (k == 0);
            req_op    = (k == 0) ? t_op : 3'($urandom);
            req_addr  = (k == 0) ? t_addr : $urandom;
            bus_grant = (k == 0) || (k == 1 + t_g) || (k > 1 + t_g && $urandom_range(0, 1) == 1);
            if (t_op != C_WRITE && k >= C && k < H) begin
                snp_valid  = '0;
                snp_result = 6'($urandom);
                for (int p = 0; p < N; p++) begin
                    if (t_off[p] >= 0 && k == C + t_off[p]) begin
                        snp_valid[p] = 1'b1;
                        snp_result[2*p +: 2] = t_val[p];
                    end else if (t_rep[p] >= 0 && k == C + t_rep[p]) begin
                        snp_valid[p] = 1'b1;
                        snp_result[2*p +: 2] = t_rval[p];
                    end
                end
            end else begin
                snp_valid  = 3'($urandom);
                snp_result = 6'($urandom);
            end
            if (hw && k >= H) wb_done = (k == H + t_w);
            else if (k < H)   wb_done = ($urandom_range(0, 1) == 1);
            else              wb_done = 1'b0;

            if (k == 0) begin
                check("accept_ready", req_ready, 1);
                check("accept_bus_valid", bus_valid, 0);
            end
            if (k >= 1 && k <= 1 + t_g) check("arb_bus_valid", bus_valid, 1);
            if (k == 1 + t_g) begin
                check("arb_bus_op", bus_op, t_op);
                check("arb_bus_addr", bus_addr, t_addr);
            end
            if (k < dc) begin
                check("done_valid_early", done_valid, 0);
                check("done_result_hold", done_result, prev_res);
            end else begin
                check("done_valid", done_valid, 1);
                check("done_result", done_result, er);
                check("done_mesi", done_mesi, em);
                check("done_err", done_err, ee);
                check("done_ready_low", req_ready, 0);
            end
            tick();
        end

        req_valid = 1'b0; bus_grant = 1'b0; snp_valid = '0; wb_done = 1'b0;
        check("post_done_valid", done_valid, 0);
        check("post_ready", req_ready, 1);
        check("post_result_hold", done_result, er);
        check("post_mesi_hold", done_mesi, em);
        check("post_err_hold", done_err, ee);
        // keep the held-values bookkeeping quiet for the linter
        if (prev_mesi === 2'bxx && prev_err === 1'bx) tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0;
        bus_grant = 1'b0; snp_valid = '0; snp_result = '0; wb_done = 1'b0;
        tick(); tick(); tick();
        check("rst_ready", req_ready, 1);
        check("rst_bus_valid", bus_valid, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_result", done_result, R_NOHIT);
        check("rst_done_mesi", done_mesi, M_I);
        check("rst_done_err", done_err, 0);
        rst = 1'b0;

        // READ, all peers NOHIT on the first collect cycle -> done at T+3
        set_txn(C_READ, 32'h1000, 0, -1);
        for (int p = 0; p < N; p++) set_peer(p, 0, R_NOHIT, -1, R_NOHIT);
        idle_junk(); run_txn();

        // READ, HIT / NOHIT / HITM over three cycles, writeback two cycles later
        set_txn(C_READ, 32'h2000, 0, 2);
        set_peer(0, 0, R_HIT, -1, R_NOHIT);
        set_peer(1, 1, R_NOHIT, -1, R_NOHIT);
        set_peer(2, 2, R_HITM, -1, R_NOHIT);
        idle_junk(); run_txn();

        // RWIM with one silent peer -> collect timeout
        set_txn(C_RWIM, 32'h3000, 0, -1);
        set_peer(0, 0, R_NOHIT, -1, R_NOHIT);
        set_peer(1, 0, R_NOHIT, -1, R_NOHIT);
        idle_junk(); run_txn();

        // WRITE with a late grant: no snoop phase
        set_txn(C_WRITE, 32'hABC0, 5, -1);
        idle_junk(); run_txn();

        // peer 1 repeats with HITM after its first HIT: repeat ignored
        set_txn(C_READ, 32'h4000, 1, 0);
        set_peer(0, 0, R_NOHIT, -1, R_NOHIT);
        set_peer(1, 0, R_HIT, 1, R_HITM);
        set_peer(2, 2, R_NOHIT, -1, R_NOHIT);
        idle_junk(); run_txn();

        // INVALIDATE with an illegal encoding and a HITM: no writeback wait
        set_txn(C_INV, 32'h5000, 0, -1);
        set_peer(0, 1, R_ILL, -1, R_NOHIT);
        set_peer(1, 0, R_HITM, -1, R_NOHIT);
        set_peer(2, 0, R_HIT, -1, R_NOHIT);
        idle_junk(); run_txn();

        // READ with HITM and no writeback -> wait timeout
        set_txn(C_READ, 32'h6000, 2, -1);
        set_peer(0, 0, R_NOHIT, -1, R_NOHIT);
        set_peer(1, 1, R_HITM, -1, R_NOHIT);
        set_peer(2, 0, R_NOHIT, -1, R_NOHIT);
        idle_junk(); run_txn();

        // reset while collecting: abort without a completion pulse
        idle_junk();
        req_valid = 1'b1; req_op = C_READ; req_addr = 32'h7000;
        tick();
        req_valid = 1'b0; bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0; snp_valid = 3'b001; snp_result = 6'b10_10_01;
        tick();
        snp_valid = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_done_valid", done_valid, 0);
        check("rst_mid_ready", req_ready, 1);
        check("rst_mid_bus_valid", bus_valid, 0);
        check("rst_mid_done_result", done_result, R_NOHIT);
        tick();
        check("rst_mid_after_done_valid", done_valid, 0);

        // randomized transactions
        for (int n = 0; n < 30; n++) begin
            set_txn(3'($urandom_range(1, 4)), $urandom, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4)));
            for (int p = 0; p < N; p++) begin
                int off, rep;
                logic [1:0] v;
                off = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
                v   = ($urandom_range(0, 11) == 0) ? R_ILL : 2'($urandom_range(0, 2));
                rep = (off >= 0 && $urandom_range(0, 1) == 1) ? off + 1 + int'($urandom_range(0, 2)) : -1;
                set_peer(p, off, v, rep, 2'($urandom));
            end
            idle_junk(); run_txn();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
